// File: rtl/linebuffer_reader_if.sv
// AXI4-Stream bundle carrying one pixel per beat from the line-buffer reader.
// tuser marks the first pixel of a frame, tlast the final pixel of a line.
interface linebuffer_reader_if #(
    parameter int C_DATA_WIDTH = 8
);
    logic                    tvalid;
    logic                    tready;
    logic [C_DATA_WIDTH-1:0] tdata;
    logic                    tuser;
    logic                    tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/linebuffer_reader.sv
// Streams one line out of a synchronous-read line buffer onto AXI4-Stream,
// using a 4-entry skid FIFO with read credits so back-pressure never drops data.
module linebuffer_reader #(
    parameter int C_DATA_WIDTH    = 8,
    parameter int C_ADDRESS_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [C_ADDRESS_WIDTH-1:0] width_m1,
    input  logic                       sof,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [C_ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [C_DATA_WIDTH-1:0]    rd_data,
    linebuffer_reader_if.master        m_axis
);
    typedef enum logic {IDLE, READ} state_t;

    state_t                     state_reg, state_next;
    logic [C_ADDRESS_WIDTH-1:0] addr_reg;
    logic [C_ADDRESS_WIDTH-1:0] width_reg;
    logic                       sof_reg;
    logic                       issued_all_reg;
    logic                       inflight_reg;
    logic                       inflight_user_reg;
    logic                       inflight_last_reg;
    logic                       done_reg;

    logic [C_DATA_WIDTH-1:0]    fifo_data [4];
    logic                       fifo_user [4];
    logic                       fifo_last [4];
    logic [1:0]                 wr_ptr_reg, rd_ptr_reg;
    logic [2:0]                 count_reg;

    logic accept, push, pop, head_valid, head_last;

    assign head_valid = (count_reg != 3'd0);
    assign head_last  = fifo_last[rd_ptr_reg];
    assign push       = inflight_reg;

    // Outputs are forced to zero while the FIFO is empty so stale entries never leak.
    assign m_axis.tvalid = head_valid;
    assign m_axis.tdata  = head_valid ? fifo_data[rd_ptr_reg] : '0;
    assign m_axis.tuser  = head_valid & fifo_user[rd_ptr_reg];
    assign m_axis.tlast  = head_valid & head_last;

    assign busy    = (state_reg == READ);
    assign done    = done_reg;
    assign rd_addr = addr_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        pop        = head_valid & m_axis.tready;
        // A read is only issued when its data is guaranteed a FIFO slot on return.
        rd_en      = (state_reg == READ) && !issued_all_reg &&
                     (({1'b0, count_reg} + {3'b000, inflight_reg}) < 4'd4);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                if (pop && head_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg          <= '0;
            width_reg         <= '0;
            sof_reg           <= 1'b0;
            issued_all_reg    <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_user_reg <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
        end else begin
            done_reg          <= pop && head_last;
            inflight_reg      <= rd_en;
            inflight_user_reg <= sof_reg && (addr_reg == '0);
            inflight_last_reg <= (addr_reg == width_reg);

            if (accept) begin
                addr_reg       <= '0;
                width_reg      <= width_m1;
                sof_reg        <= sof;
                issued_all_reg <= 1'b0;
            end else if (rd_en) begin
                // Hold at the final address instead of wrapping past the line end.
                if (addr_reg == width_reg) issued_all_reg <= 1'b1;
                else                       addr_reg       <= addr_reg + 1'b1;
            end

            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= rd_data;
            fifo_user[wr_ptr_reg] <= inflight_user_reg;
            fifo_last[wr_ptr_reg] <= inflight_last_reg;
        end
    end
endmodule

// File: tb/tb_linebuffer_reader.sv
// Randomised bench for linebuffer_reader: a queue of expected beats is built
// from the line-buffer contents at each accepted start and matched against the stream.
module tb_linebuffer_reader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] width_m1;
    logic       sof;
    logic       busy, done, rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] ram [256];

    linebuffer_reader_if #(.C_DATA_WIDTH(8)) axis ();

    linebuffer_reader #(.C_DATA_WIDTH(8), .C_ADDRESS_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .width_m1 (width_m1),
        .sof      (sof),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m_axis   (axis.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read line buffer.
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cur_w = 0;
    int    cyc = 0;
    int    line_beats = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    int    tready_mode = 0;
    logic  prev_stall = 1'b0;
    logic  prev_tlast_hs = 1'b0;
    logic [9:0] prev_beat = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // tready pattern: 0 always high, 1 toggling, 2 random, 3 held low.
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0: axis.tready = 1'b1;
                1: axis.tready = ~axis.tready;
                2: axis.tready = 1'($urandom_range(0, 1));
                default: axis.tready = 1'b0;
            endcase
        end
    end

    // Stream monitor: beat order/content, stall stability, done timing, read range.
    always @(negedge clk) begin
        beat_t e;
        logic  hs;
        cyc++;
        if (reset) begin
            prev_stall    = 1'b0;
            prev_tlast_hs = 1'b0;
        end else begin
            if (done || prev_tlast_hs) check("done_pulse", done, prev_tlast_hs);
            if (prev_tlast_hs) check("busy_in_done_cycle", busy, 0);
            if (prev_stall) begin
                check("stall_tvalid", axis.tvalid, 1);
                check("stall_beat", {axis.tdata, axis.tuser, axis.tlast}, prev_beat);
            end
            if (rd_en) check("rd_addr_range", (int'(rd_addr) <= cur_w), 1);
            hs = axis.tvalid && axis.tready;
            if (hs) begin
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("tdata", axis.tdata, e.data);
                    check("tuser", axis.tuser, e.user);
                    check("tlast", axis.tlast, e.last);
                end
                if (line_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                line_beats++;
            end
            prev_stall    = axis.tvalid && !axis.tready;
            prev_beat     = {axis.tdata, axis.tuser, axis.tlast};
            prev_tlast_hs = hs && axis.tlast;
        end
    end

    // Raises start now; the caller guarantees the DUT will accept it this cycle.
    task automatic start_line(input int w, input bit s, input bit chk_lat);
        start    = 1'b1;
        width_m1 = 8'(w);
        sof      = s;
        for (int i = 0; i <= w; i++) exp_q.push_back(beat_t'{ram[i], (i == 0) && s, i == w});
        cur_w      = w;
        line_beats = 0;
        @(posedge clk); #1;
        start    = 1'b0;
        width_m1 = 8'($urandom);
        sof      = 1'($urandom_range(0, 1));
        if (chk_lat) begin
            @(negedge clk);
            check("busy_after_start", busy, 1);
            check("first_rd_en", rd_en, 1);
            check("first_rd_addr", rd_addr, 0);
            @(negedge clk);
            check("tvalid_at_n2", axis.tvalid, 0);
            @(negedge clk);
            check("tvalid_at_n3", axis.tvalid, 1);
        end
    endtask

    // Returns at the negedge of the done cycle.
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 5000);
        check("line_done_timeout", done, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic idle_start(input int w, input bit s, input bit chk_lat);
        @(posedge clk); #1;
        start_line(w, s, chk_lat);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; width_m1 = '0; sof = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tuser", axis.tuser, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_tdata", axis.tdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Ramp line, full-rate.
        tready_mode = 0;
        idle_start(7, 1'b1, 1'b1);
        wait_done();
        check("burst8_cycles", last_cyc - first_cyc, 7);

        // Toggling back-pressure on random data.
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        tready_mode = 1;
        idle_start(15, 1'b0, 1'b1);
        wait_done();

        // Single-beat line.
        tready_mode = 0;
        idle_start(0, 1'b0, 1'b1);
        wait_done();

        // Full-depth line.
        idle_start(255, 1'b1, 1'b0);
        wait_done();
        check("burst256_cycles", last_cyc - first_cyc, 255);

        // Start while busy is ignored; start in the done cycle is taken at once.
        idle_start(20, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; width_m1 = 8'd3; sof = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        start_line(5, 1'b1, 1'b1);
        wait_done();

        // Reset in the middle of a line.
        idle_start(9, 1'b1, 1'b0);
        begin
            int n = 0;
            do begin
                @(negedge clk); #1;
                n++;
            end while (line_beats < 4 && n < 200);
            check("midline_reach_beat3", line_beats >= 4, 1);
        end
        tready_mode = 3;
        axis.tready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_tvalid", axis.tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", rd_en, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_beat", axis.tvalid, 0);
        end
        tready_mode = 0;
        idle_start(9, 1'b0, 1'b1);
        wait_done();

        // Random lines with random back-pressure and occasional back-to-back starts.
        tready_mode = 2;
        for (int t = 0; t < 10; t++) begin
            int w;
            w = (t == 9) ? 255 : int'($urandom_range(0, 40));
            for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1 && t > 0) start_line(w, 1'($urandom_range(0, 1)), 1'b0);
            else idle_start(w, 1'($urandom_range(0, 1)), 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
